// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB-first.
// Operands load on an accepted start; the sum streams out one bit per clock.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             bit_out,
    output logic             bit_valid
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_sr_q, sum_sr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
    logic             fa_s, fa_c, load;

    assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_c = (a_sr_q[0] & b_sr_q[0]) | ((a_sr_q[0] ^ b_sr_q[0]) & carry_q);
    assign load = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (count_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // sum_sr and carry are held outside RUN so the last result stays visible in IDLE.
    always_comb begin
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        count_d     = count_q;
        carry_d     = carry_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        if (load) begin
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            count_d = '0;
        end else if (state_q == RUN) begin
            a_sr_d      = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d      = {1'b0, b_sr_q[WIDTH-1:1]};
            sum_sr_d    = {fa_s, sum_sr_q[WIDTH-1:1]};
            carry_d     = fa_c;
            bit_out_d   = fa_s;
            bit_valid_d = 1'b1;
            if (count_q != LAST) count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        sum       = sum_sr_q;
        cout      = carry_q;
        bit_out   = bit_out_q;
        bit_valid = bit_valid_q;
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed + random bench for serial_adder at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_serial_adder;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cin = 1'b0, wide = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy8, done8, cout8, bo8, bv8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16, bo16, bv16;
    logic [15:0] sum16;
    logic        start8, start16;
    logic        o_busy, o_done, o_cout, o_bo, o_bv;
    logic [15:0] o_sum;
    int          checks = 0, errors = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    assign start8  = start & ~wide;
    assign start16 = start & wide;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .bit_out(bo8), .bit_valid(bv8)
    );
    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(start16), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .bit_out(bo16), .bit_valid(bv16)
    );

    assign o_busy = wide ? busy16 : busy8;
    assign o_done = wide ? done16 : done8;
    assign o_cout = wide ? cout16 : cout8;
    assign o_bo   = wide ? bo16 : bo8;
    assign o_bv   = wide ? bv16 : bv8;
    assign o_sum  = wide ? sum16 : {8'h00, sum8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs_res();
        return wide ? {o_cout, o_sum} : {8'h00, o_cout, o_sum[7:0]};
    endfunction

    task automatic pop_chk(input string tag);
        logic [16:0] ex;
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else begin
            ex = sb.pop_front();
            chk(tag, 32'(obs_res()), 32'(ex));
        end
    endtask

    task automatic run_op(input logic w16, input logic [15:0] av, input logic [15:0] bv, input logic ci);
        int w, lat, nbv;
        logic [16:0] full, ex;
        logic [15:0] strm, ex_sum;
        bit seen;
        w = w16 ? 16 : 8;
        if (!w16) begin av[15:8] = '0; bv[15:8] = '0; end
        full   = {1'b0, av} + {1'b0, bv} + 17'(ci);
        ex     = w16 ? full : {8'h00, full[8:0]};
        ex_sum = w16 ? ex[15:0] : {8'h00, ex[7:0]};
        sb.push_back(ex);
        @(negedge clk);
        wide = w16; a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(o_busy), 32'd1);
        chk("bit_valid_first_run", 32'(o_bv), 32'd0);
        strm = '0; nbv = 0; seen = 0; lat = 0;
        for (int k = 1; k <= w + 3 && !seen; k++) begin
            @(negedge clk);
            if (o_bv) begin
                if (nbv < 16) strm[nbv] = o_bo;
                nbv++;
            end
            if (o_done) begin seen = 1; lat = k; end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(w));
        chk("bit_valid_count", 32'(nbv), 32'(w));
        chk("bit_stream", 32'(strm), 32'(ex_sum));
        pop_chk("sum_cout");
        @(negedge clk);
        chk("done_one_cycle", 32'(o_done), 32'd0);
        chk("sum_hold_idle", 32'(o_sum), 32'(ex_sum));
    endtask

    initial begin
        int ndone, d1, d2;
        // reset state
        #2;
        chk("reset_outs8", {19'd0, busy8, done8, cout8, bo8, bv8, sum8}, 32'd0);
        chk("reset_outs16", {11'd0, busy16, done16, cout16, bo16, bv16, sum16}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // basic add and wrap-around
        run_op(1'b0, 16'h005A, 16'h003C, 1'b0);
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0);
        run_op(1'b0, 16'h00FF, 16'h00FF, 1'b1);

        // start while busy is ignored
        sb.push_back(17'h00030);
        @(negedge clk);
        wide = 1'b0; a = 16'h10; b = 16'h20; cin = 1'b0; start = 1'b1;
        ndone = 0; d1 = -1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 2) begin start = 1'b1; a = 16'hAA; b = 16'h55; end
            if (k == 3) start = 1'b0;
            if (o_done) begin
                ndone++;
                d1 = k;
                pop_chk("busy_start_sum");
            end
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_latency", 32'(d1), 32'd8);

        // back-to-back with start held high
        sb.push_back(17'h00003);
        @(negedge clk);
        a = 16'h01; b = 16'h02; cin = 1'b0; start = 1'b1;
        ndone = 0; d1 = -1; d2 = -1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (o_done) begin
                ndone++;
                pop_chk("b2b_sum");
                if (ndone == 1) begin
                    d1 = k; a = 16'h80; b = 16'h80;
                    sb.push_back(17'h00100);
                end else d2 = k;
            end else if (ndone == 1 && start) begin
                chk("b2b_accept_on_done", 32'(o_busy), 32'd1);
                start = 1'b0;
            end
        end
        chk("b2b_ndone", 32'(ndone), 32'd2);
        chk("b2b_first_latency", 32'(d1), 32'd8);
        chk("b2b_spacing", 32'(d2 - d1), 32'd9);

        // asynchronous reset in RUN cycle 4
        @(negedge clk);
        a = 16'h33; b = 16'h44; start = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        #2 reset = 1'b1;
        #1 chk("async_reset_outs", {19'd0, busy8, done8, cout8, bo8, bv8, sum8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_done || o_busy) ndone++;
        end
        chk("reset_no_done", 32'(ndone), 32'd0);
        run_op(1'b0, 16'h0007, 16'h0009, 1'b0);

        // random sweep at both widths
        for (int i = 0; i < 1000; i++)
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 1000; i++)
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop. It accepts two parallel operands plus a carry-in on a start handshake. It then adds them LSB-first, one bit per clock, streaming each sum bit out as produced. On completion it presents the parallel sum and carry-out. It sits directly upstream of parallel consumers of the adder result, and trades ripple-carry area for WIDTH cycles of latency.

## Interface

- WIDTH, default 8: operand/sum width in bits; legal range 2..32.

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled on rising clk; accepted only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepting edge only.
- b  in  WIDTH  operand B; captured on the accepting edge only.
- cin  in  1  carry-in; captured on the accepting edge, seeds the carry flip-flop.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse in DONE; sum/cout valid.
- sum  out  WIDTH  result shift register; valid from DONE until the next accepted start.
- cout  out  1  final carry; valid with sum.
- bit_out  out  1  most recently computed sum bit.
- bit_valid  out  1  high for one cycle per new bit_out value.

## Operation

- Datapath registers: a_sr, b_sr (WIDTH each), carry (1), sum_sr (WIDTH), count (clog2(WIDTH) bits).
- Full-adder cell is combinational on a_sr[0], b_sr[0], carry:
  - s = a_sr[0] ^ b_sr[0] ^ carry
  - c = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry)
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE with start=1: load a_sr=a, b_sr=b, carry=cin, count=0; go to RUN. Otherwise stay in IDLE.
- RUN, every edge:
  - a_sr, b_sr shift right by one (zero fill).
  - sum_sr = {s, sum_sr[WIDTH-1:1]}.
  - carry = c.
  - bit_out = s, bit_valid = 1.
  - count increments.
  - When count == WIDTH-1 on this edge, go to DONE and do not increment count.
- RUN ignores start. Operands on a/b are not sampled.
- DONE lasts exactly one cycle.
  - done = 1, sum = sum_sr, cout = carry.
  - With start=1: reload exactly as from IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- IDLE holds sum_sr/carry, so sum/cout keep the last result indefinitely.
- Arithmetic is unsigned modulo 2^WIDTH; the overflow bit is cout. {cout,sum} = a + b + cin.
- Reset mid-operation: the operation is abandoned immediately. No done pulse is produced, and the state is IDLE on the first edge after reset deasserts.

## Timing

- Reset values: busy=0, done=0, sum=0, cout=0, bit_out=0, bit_valid=0. Internal state is IDLE, count=0, carry=0.
- Start accepted at edge E0: busy=1 after E0.
- Bit k (k=0..WIDTH-1) is computed at edge E(k+1). bit_out/bit_valid reflect bit k in the cycle after E(k+1).
- After E(WIDTH): state=DONE, busy=0, done=1, sum/cout final.
- Latency from accepting edge to done is WIDTH cycles. Throughput is one result per WIDTH+1 cycles with start held high.
- bit_valid is low in the first RUN cycle and high in the following WIDTH cycles, the last of which is the DONE cycle.
- During RUN, sum shows partial shift contents and must not be used. Consumers qualify sum with done or IDLE-after-done.
- done is never asserted for two consecutive cycles.

## Test plan

- **Basic add:** WIDTH=8; start with a=0x5A, b=0x3C, cin=0 → done exactly 8 cycles after the accepting edge; sum=0x96, cout=0; bit_out stream LSB-first is 0,1,1,0,1,0,0,1.
- **Wrap-around:** a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- **Start while busy:** start a=0x10, b=0x20; pulse start with a=0xAA, b=0x55 during RUN cycle 3 → ignored; result is sum=0x30, cout=0 after 8 cycles; exactly one done pulse.
- **Back-to-back:** hold start high with a=0x01, b=0x02, then a=0x80, b=0x80 on the DONE cycle → first done gives sum=0x03; second operation accepted on the DONE edge; second done 9 cycles after the first gives sum=0x00, cout=1.
- **Reset mid-op:** assert reset asynchronously (between clock edges) in RUN cycle 4 → all outputs 0 immediately; no done pulse; after release, a fresh start a=0x07, b=0x09 gives sum=0x10.
- **Random sweep:** 1000 random a/b/cin values at WIDTH=8 and WIDTH=16 → {cout,sum} == a+b+cin for every run; bit_valid count is WIDTH per operation.
